// File: rtl/alu_driver.sv
// Command front-end for the 32-bit combinational ALU: FIFO-buffered commands, settle-timed capture, held response.
// Optional ALU_DRV_CHECK_EN builds a reference model that drives a sticky chk_err on result mismatch.
module alu_driver #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_res,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_res,
  output logic        rsp_zero,
  output logic [2:0]  rsp_op,
  output logic        busy,
  output logic        chk_err
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);
  localparam logic [CNTW-1:0] FULL_COUNT  = CNTW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [66:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CNTW-1:0] r_count;
  logic [CW-1:0]   r_cnt;

  logic [31:0]     r_alu_a;
  logic [31:0]     r_alu_b;
  logic [2:0]      r_alu_op;
  logic            r_rsp_valid;
  logic [31:0]     r_rsp_res;
  logic            r_rsp_zero;
  logic [2:0]      r_rsp_op;

  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_capture;
  logic            w_rsp_clear;
  logic [66:0]     w_head;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_COUNT);
  assign cmd_ready = !w_full && !rst;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_head    = r_mem[r_rptr];

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_rsp_clear = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        // Accepting a response with work queued skips IDLE to keep one response per SETTLE+1 cycles.
        if (rsp_ready) begin
          w_rsp_clear = 1'b1;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {cmd_op, cmd_b, cmd_a};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_cnt       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_res   <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_op    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr   <= r_rptr + AW'(1);
        r_alu_a  <= w_head[31:0];
        r_alu_b  <= w_head[63:32];
        r_alu_op <= w_head[66:64];
        r_cnt    <= SETTLE_LOAD;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_res   <= alu_res;
        r_rsp_zero  <= alu_zero;
        r_rsp_op    <= r_alu_op;
      end else if (w_rsp_clear) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign alu_A     = r_alu_a;
  assign alu_B     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign rsp_valid = r_rsp_valid;
  assign rsp_res   = r_rsp_res;
  assign rsp_zero  = r_rsp_zero;
  assign rsp_op    = r_rsp_op;
  assign busy      = (r_state != S_IDLE) || !w_empty;

`ifdef ALU_DRV_CHECK_EN
  logic [31:0] w_ref;
  logic        r_chk_err;

  always_comb begin
    w_ref = '0;
    case (r_alu_op)
      3'b000:  w_ref = r_alu_a & r_alu_b;
      3'b001:  w_ref = r_alu_a | r_alu_b;
      3'b010:  w_ref = r_alu_a + r_alu_b;
      3'b011:  w_ref = r_alu_a ^ r_alu_b;
      3'b100:  w_ref = ~(r_alu_a | r_alu_b);
      3'b101:  w_ref = r_alu_a >> r_alu_b[4:0];
      3'b110:  w_ref = r_alu_a + r_alu_b;
      default: w_ref = {31'd0, (r_alu_a >= r_alu_b)};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chk_err <= 1'b0;
    end else if (w_capture && (alu_res != w_ref)) begin
      r_chk_err <= 1'b1;
    end
  end

  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_driver.sv
// Directed self-checking bench for alu_driver (DEPTH=4, SETTLE=1) with a behavioural ALU stub.
module tb_alu_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [2:0]  cmd_op;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [2:0]  alu_op;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_res;
  logic        rsp_zero;
  logic [2:0]  rsp_op;
  logic        busy;
  logic        chk_err;

  logic        force_zero;
  logic [31:0] alu_calc;
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

`ifdef ALU_DRV_CHECK_EN
  localparam logic EXP_CHK = 1'b1;
`else
  localparam logic EXP_CHK = 1'b0;
`endif

  alu_driver #(.DEPTH(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_res(alu_res), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_zero(rsp_zero), .rsp_op(rsp_op),
    .busy(busy), .chk_err(chk_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the external ALU; force_zero models a broken result path.
  always_comb begin
    case (alu_op)
      3'b000:  alu_calc = alu_A & alu_B;
      3'b001:  alu_calc = alu_A | alu_B;
      3'b010:  alu_calc = alu_A + alu_B;
      3'b011:  alu_calc = alu_A ^ alu_B;
      3'b100:  alu_calc = ~(alu_A | alu_B);
      3'b101:  alu_calc = alu_A >> alu_B[4:0];
      3'b110:  alu_calc = alu_A + alu_B;
      default: alu_calc = {31'd0, (alu_A >= alu_B)};
    endcase
    alu_res = force_zero ? 32'd0 : alu_calc;
  end
  assign alu_zero = (alu_res == 32'd0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bit done;
    done = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (cmd_ready) done = 1;
      tick();
    end
    cmd_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL push_accept: cmd_ready never high, got 0 expected 1");
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (rsp_valid) ok = 1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; force_zero = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0;
    tick(); tick();
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready_in_rst: got %b expected 0", cmd_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready_after: got %b expected 1", cmd_ready); end
    checks++;
    if ({rsp_valid, busy, chk_err, rsp_zero} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {rsp_valid, busy, chk_err, rsp_zero});
    end
    checks++;
    if ({alu_A, alu_B, alu_op, rsp_res, rsp_op} !== '0) begin
      errors++; $display("FAIL reset_data: got A=%h B=%h op=%h res=%h rop=%h expected all 0", alu_A, alu_B, alu_op, rsp_res, rsp_op);
    end
  endtask

  task automatic test_basic();
    int t0;
    rsp_ready = 1'b0;
    push(32'd5, 32'd3, 3'b010);
    t0 = cyc;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_e0: got %b expected 0", rsp_valid); end
    tick();
    checks++;
    if ({rsp_valid, busy} !== 2'b01 || alu_A !== 32'd5 || alu_B !== 32'd3 || alu_op !== 3'b010) begin
      errors++; $display("FAIL basic_drive: got valid=%b busy=%b A=%h B=%h op=%b expected 0 1 5 3 010", rsp_valid, busy, alu_A, alu_B, alu_op);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || (cyc - t0) != 2) begin
      errors++; $display("FAIL basic_latency: got valid=%b after %0d cycles expected 1 after 2", rsp_valid, cyc - t0);
    end
    checks++;
    if (rsp_res !== 32'd8 || rsp_op !== 3'b010 || rsp_zero !== 1'b0) begin
      errors++; $display("FAIL basic_rsp: got res=%h op=%b z=%b expected 8 010 0", rsp_res, rsp_op, rsp_zero);
    end
    tick(); tick(); tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_res !== 32'd8) begin
      errors++; $display("FAIL basic_hold: got valid=%b res=%h expected 1 8", rsp_valid, rsp_res);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_release: got valid=%b busy=%b expected 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_ops();
    logic [31:0] va [9];
    logic [31:0] vb [9];
    logic [2:0]  vo [9];
    logic [31:0] ve [9];
    bit ok;
    va[0] = 32'd3;          vb[0] = 32'd5;          vo[0] = 3'b111; ve[0] = 32'd0;
    va[1] = 32'd5;          vb[1] = 32'd3;          vo[1] = 3'b111; ve[1] = 32'd1;
    va[2] = 32'd7;          vb[2] = 32'd7;          vo[2] = 3'b111; ve[2] = 32'd1;
    va[3] = 32'h8000_0000;  vb[3] = 32'h0000_003F;  vo[3] = 3'b101; ve[3] = 32'd1;
    va[4] = 32'h0000_00F0;  vb[4] = 32'h0000_003C;  vo[4] = 3'b000; ve[4] = 32'h0000_0030;
    va[5] = 32'hFFFF_FFFF;  vb[5] = 32'd1;          vo[5] = 3'b010; ve[5] = 32'd0;
    va[6] = 32'd1;          vb[6] = 32'd2;          vo[6] = 3'b100; ve[6] = 32'hFFFF_FFFC;
    va[7] = 32'h0000_00A5;  vb[7] = 32'h0000_000F;  vo[7] = 3'b011; ve[7] = 32'h0000_00AA;
    va[8] = 32'hFFFF_FFFF;  vb[8] = 32'd2;          vo[8] = 3'b110; ve[8] = 32'd1;
    for (int i = 0; i < 9; i++) begin
      push(va[i], vb[i], vo[i]);
      wait_rsp(ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL op_timeout[%0d]: got no rsp_valid expected 1", i);
      end else begin
        checks++;
        if (rsp_res !== ve[i] || rsp_op !== vo[i] || rsp_zero !== (ve[i] == 32'd0)) begin
          errors++; $display("FAIL op_result[%0d]: got res=%h op=%b z=%b expected res=%h op=%b z=%b",
                             i, rsp_res, rsp_op, rsp_zero, ve[i], vo[i], (ve[i] == 32'd0));
        end
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    checks++;
    if (chk_err !== 1'b0) begin errors++; $display("FAIL op_chk_clean: got %b expected 0", chk_err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [5];
    int          t [5];
    int          n;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'(16 * i + 1), 32'(i + 2), 3'b010);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got cmd_ready=%b expected 0", cmd_ready); end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_res !== 32'd3) begin
      errors++; $display("FAIL b2b_first_held: got valid=%b res=%h expected 1 3", rsp_valid, rsp_res);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_stays: got %b expected 0", cmd_ready); end
    rsp_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 40 && n < 5; k++) begin
      if (rsp_valid) begin
        got[n] = rsp_res; t[n] = cyc; n++;
      end
      if (k == 1) begin
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_rise: got %b expected 1", cmd_ready); end
      end
      if (n < 5) tick();
    end
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL b2b_count: got %0d responses expected 5", n);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] !== 32'(17 * i + 3)) begin
          errors++; $display("FAIL b2b_order[%0d]: got %h expected %h", i, got[i], 32'(17 * i + 3));
        end
      end
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (t[i] - t[i-1] != 2) begin
          errors++; $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 2", i, t[i] - t[i-1]);
        end
      end
    end
    tick();
    rsp_ready = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got busy=%b valid=%b expected 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit stray;
    rsp_ready = 1'b0;
    push(32'd10, 32'd1, 3'b010);
    push(32'd20, 32'd2, 3'b010);
    push(32'd30, 32'd3, 3'b010);
    push(32'd40, 32'd4, 3'b010);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || alu_A !== 32'd20) begin
      errors++; $display("FAIL rstmid_in_wait: got valid=%b busy=%b A=%h expected 0 1 14", rsp_valid, busy, alu_A);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 || rsp_res !== 32'd0 || alu_A !== 32'd0) begin
      errors++; $display("FAIL rstmid_cleared: got valid=%b busy=%b ready=%b res=%h A=%h expected 0 0 0 0 0",
                         rsp_valid, busy, cmd_ready, rsp_res, alu_A);
    end
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy !== 1'b0 || rsp_valid !== 1'b0) stray = 1;
    end
    checks++;
    if (stray) begin errors++; $display("FAIL rstmid_fifo_empty: got busy/valid activity expected none"); end
    push(32'd100, 32'd23, 3'b010);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_res !== 32'd123 || rsp_op !== 3'b010) begin
      errors++; $display("FAIL rstmid_recover: got ok=%b res=%h op=%b expected 1 7b 010", ok, rsp_res, rsp_op);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_checker();
    bit ok;
    force_zero = 1'b1;
    push(32'd1, 32'd2, 3'b001);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_res !== 32'd0 || rsp_zero !== 1'b1) begin
      errors++; $display("FAIL chk_forced_rsp: got ok=%b res=%h z=%b expected 1 0 1", ok, rsp_res, rsp_zero);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    force_zero = 1'b0;
    checks++;
    if (chk_err !== EXP_CHK) begin errors++; $display("FAIL chk_set: got %b expected %b", chk_err, EXP_CHK); end
    push(32'd6, 32'd1, 3'b001);
    wait_rsp(ok);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick(); tick();
    checks++;
    if (!ok || chk_err !== EXP_CHK) begin
      errors++; $display("FAIL chk_sticky: got ok=%b chk=%b expected 1 %b", ok, chk_err, EXP_CHK);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (chk_err !== 1'b0) begin errors++; $display("FAIL chk_reset: got %b expected 0", chk_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ops();
    test_back_to_back();
    test_reset_mid();
    test_checker();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
